fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage for the 5-stage DLX pipeline. It sits directly upstream of the register/decode stage. It owns the PC and issues one word fetch at a time to a variable-latency instruction memory. It delivers the instruction plus its PC+4 and PC+8 byte addresses to decode, and honours decode-resolved branch/jump redirects with a single architectural delay slot. The stall from the hazard logic freezes its outputs.

## Interface
Parameters:
- RESET_PC, 30'h0, word address of the first fetch after reset
- NOP_INSTR, 32'h0000_0015, bubble instruction (R-type funct 21, nop)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold all outputs to decode; redirects are ignored while high
- branch  in  1  taken branch in decode
- branch_target  in  30  word target for branch
- jump  in  1  jump/jal in decode (register-form with jar)
- jar  in  1  jump target is jr_target (register), else branch_target
- jr_target  in  30  register-sourced word target (busA[31:2])
- imem_req  out  1  fetch request
- imem_addr  out  30  word address of request
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid; earliest one cycle after gnt
- imem_rdata  in  32  instruction word
- instruction  out  32  instruction to decode
- delayslot  out  32  byte address of fetched PC+4
- delayslot2  out  32  byte address of fetched PC+8 (link value)
- if_valid  out  1  instruction is real (not a bubble)

## Operation
- Registers: pc (next word to fetch), fetch_pc (outstanding word), 1-entry response buffer, pending redirect (redir_v, redir_pc).
- FSM states:
  - S_BOOT: state after reset; imem_req=0; goes to S_REQ next cycle.
  - S_REQ: imem_req=1, imem_addr=pc. On gnt: fetch_pc<=pc, pc<=next_pc, then S_WAIT.
  - S_WAIT: on rvalid with stall low, load outputs and go to S_REQ. On rvalid with stall high, capture into the buffer and go to S_FULL.
  - S_FULL: when stall is low, move the buffer to the outputs and go to S_REQ.
- Output load: instruction<=rdata/buffer; delayslot<={fetch_pc+1,2'b00}; delayslot2<={fetch_pc+2,2'b00}; if_valid<=1.
- Any cycle with stall low and nothing loaded: instruction<=NOP_INSTR, if_valid<=0, delayslot/delayslot2 hold.
- Stall high: every output holds.
- Redirect is accepted only when stall is low and (branch|jump).
  - Target: jump&jar → jr_target; otherwise branch_target.
  - If jump and branch are both asserted, the jump wins.
- Delay-slot rule: the first request granted after the branch was delivered is the delay slot and is always fetched and delivered.
  - Redirect in S_REQ without gnt: redir_v<=1, redir_pc<=target. The next gnt sets pc<=redir_pc and clears redir_v.
  - Redirect in S_REQ with gnt the same cycle: pc<=target.
  - Redirect in S_WAIT/S_FULL (delay slot already granted): pc<=target directly.
- next_pc = redir_v ? redir_pc : pc+1. A second redirect while redir_v is set overwrites it (latest wins).
- PC arithmetic is 30-bit modulo 2^30. 30'h3FFFFFFF+1 wraps to 0, and delayslot wraps the same way.

## Timing
- Reset (async) values:
  - state=S_BOOT, pc=RESET_PC, redir_v=0, buffer empty
  - instruction=NOP_INSTR, delayslot=0, delayslot2=0, if_valid=0, imem_req=0
- Fetch latency: gnt at cycle t, rvalid at t+k (k≥1), outputs visible after the edge ending t+k. Peak throughput is one instruction per 2 cycles.
- At most one outstanding request. rvalid outside S_WAIT is ignored.
- Reset asserted mid-request drops the outstanding fetch. Its rvalid after reset is ignored, because the state is not S_WAIT.

## Configuration
- FETCH_PERF_EN defined: adds ports perf_fetched[31:0] (increments on each output load) and perf_bubbles[31:0] (increments on each NOP_INSTR insertion). Both reset to 0 and wrap.
- FETCH_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package pipeline_pkg holds:
  - NOP_INSTR default
  - fetch state enum {S_BOOT,S_REQ,S_WAIT,S_FULL}
  - the 30-bit word-address type
- One sub-module, fetch_nextpc: redirect acceptance, pending-redirect register, next_pc mux.

## Test plan
- Reset release, memory returning rdata=addr with gnt immediate and rvalid +1 → fetches at words 0,1,2. Outputs {word0,delayslot=4,delayslot2=8,if_valid=1}, each load separated by one NOP_INSTR bubble.
- Stall held 5 cycles while rvalid arrives → outputs frozen, word captured into the buffer (S_FULL). Released one cycle after stall drops, with no lost or duplicated instruction.
- Branch at word 10 with branch_target=30'h40, gnt delayed 3 cycles → word 11 (delay slot) delivered, then word 0x40. Word 12 never requested.
- jump=1, jar=1, jr_target=30'h100 arriving the same cycle as gnt for the delay slot → next imem_addr=30'h100.
- Redirect asserted with stall high → ignored. Re-asserted with stall low → taken.
- RESET_PC=30'h3FFFFFFF → second fetch at word 0, delayslot=32'h0, delayslot2=32'h4. Async reset mid-S_WAIT, with a late rvalid arriving → outputs remain at their reset values.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared types and constants for the DLX pipeline front end.
//   word_addr_t   : 30-bit word address (byte address bits [31:2])
//   fetch_state_e : fetch-stage handshake states
//   NOP_INSTR_DEFAULT : bubble instruction (R-type funct 21)
//   byteAddr()    : word address + offset, converted to a byte address
package pipeline_pkg;

  typedef logic [29:0] word_addr_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0015;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_FULL
  } fetch_state_e;

  // Word arithmetic stays 30 bits wide, so it wraps modulo 2^30 before
  // the byte offset is appended.
  function automatic logic [31:0] byteAddr(input word_addr_t w, input word_addr_t offset);
    word_addr_t sum;
    sum = w + offset;
    return {sum, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_nextpc.sv
// fetch_nextpc
// Redirect acceptance, pending-redirect register and next-PC selection for
// the fetch stage.
// Ports:
//   clock_i, reset_i          : clock and asynchronous active-high reset
//   stall_i                   : hazard stall; redirects are ignored while high
//   branch_i, branch_target_i : taken branch and its word target
//   jump_i, jar_i, jr_target_i: jump, register-form select, register target
//   state_i                   : current fetch state
//   gnt_i                     : memory accepted the request this cycle
//   pc_i                      : current fetch PC
//   pc_d_o                    : value the fetch PC takes at the next edge
module fetch_nextpc
  import pipeline_pkg::*;
(
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         stall_i,
  input  logic         branch_i,
  input  word_addr_t   branch_target_i,
  input  logic         jump_i,
  input  logic         jar_i,
  input  word_addr_t   jr_target_i,
  input  fetch_state_e state_i,
  input  logic         gnt_i,
  input  word_addr_t   pc_i,
  output word_addr_t   pc_d_o
);

  logic       redirV_q, redirV_d;
  word_addr_t redirPc_q, redirPc_d;

  logic       accept;
  word_addr_t target;
  logic       grantFire;
  logic       slotIssued;
  word_addr_t nextSeq;

  // A redirect only counts when decode is not stalled.  A jump beats a
  // simultaneous branch, but only the register form changes the target.
  always_comb begin
    accept     = ~stall_i & (branch_i | jump_i);
    target     = (jump_i & jar_i) ? jr_target_i : branch_target_i;
    grantFire  = (state_i == S_REQ) & gnt_i;
    slotIssued = (state_i == S_WAIT) | (state_i == S_FULL);
    nextSeq    = redirV_q ? redirPc_q : (pc_i + 30'd1);
  end

  // The delay slot is the first request granted after the branch reached
  // decode.  If that grant has not happened yet the target is parked in the
  // pending register and applied at the grant; if it already happened
  // (waiting or buffered) the PC can jump straight to the target.
  always_comb begin
    pc_d_o    = pc_i;
    redirV_d  = redirV_q;
    redirPc_d = redirPc_q;
    if (grantFire) begin
      pc_d_o   = accept ? target : nextSeq;
      redirV_d = 1'b0;
    end else if (accept && slotIssued) begin
      pc_d_o   = target;
      redirV_d = 1'b0;
    end else if (accept) begin
      redirV_d  = 1'b1;
      redirPc_d = target;
    end
  end

  // Pending redirect storage; a later redirect simply overwrites it.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      redirV_q  <= 1'b0;
      redirPc_q <= '0;
    end else begin
      redirV_q  <= redirV_d;
      redirPc_q <= redirPc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage of the 5-stage DLX pipeline.  Owns the PC, issues
// one word fetch at a time to a variable-latency instruction memory and
// hands decode the instruction together with its PC+4 / PC+8 byte addresses.
// Branch/jump redirects resolved in decode take effect after one delay slot.
// Ports:
//   clock, reset       : clock and asynchronous active-high reset
//   stall              : hold every output to decode, ignore redirects
//   branch, branch_target, jump, jar, jr_target : redirect inputs from decode
//   imem_req, imem_addr: fetch request and word address
//   imem_gnt           : request accepted
//   imem_rvalid, imem_rdata : returned instruction word
//   instruction, delayslot, delayslot2, if_valid : outputs to decode
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_bubbles
// counters (output loads and bubble insertions).
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter word_addr_t  RESET_PC  = 30'h0,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [29:0] branch_target,
  input  logic        jump,
  input  logic        jar,
  input  logic [29:0] jr_target,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] delayslot,
  output logic [31:0] delayslot2,
  output logic        if_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  fetch_state_e state_q, state_d;
  word_addr_t   pc_q, pc_d;
  word_addr_t   fetchPc_q, fetchPc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ds_q, ds_d;
  logic [31:0]  ds2_q, ds2_d;
  logic         valid_q, valid_d;

  logic         grantFire;
  logic         memLoad;
  logic         bufLoad;
  logic         bufCapture;
  logic         outLoad;
  logic [31:0]  loadWord;

  // Redirect handling and next-PC selection live in their own block.
  fetch_nextpc u_nextpc (
    .clock_i         (clock),
    .reset_i         (reset),
    .stall_i         (stall),
    .branch_i        (branch),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jar_i           (jar),
    .jr_target_i     (jr_target),
    .state_i         (state_q),
    .gnt_i           (imem_gnt),
    .pc_i            (pc_q),
    .pc_d_o          (pc_d)
  );

  // FSM state register.  After reset the stage spends one cycle in S_BOOT
  // so an rvalid belonging to a fetch cut off by reset lands outside S_WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.  Only one request is ever outstanding: a new one
  // is issued only after the previous word has been handed to decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ:  if (imem_gnt) state_d = S_WAIT;
      S_WAIT: if (imem_rvalid) state_d = stall ? S_FULL : S_REQ;
      S_FULL: if (!stall) state_d = S_REQ;
      default: state_d = S_BOOT;
    endcase
  end

  // FSM outputs: the memory request plus the load/capture strobes that steer
  // the datapath.  A word arriving during a stall is parked in the buffer.
  always_comb begin
    imem_req   = 1'b0;
    grantFire  = 1'b0;
    memLoad    = 1'b0;
    bufLoad    = 1'b0;
    bufCapture = 1'b0;
    case (state_q)
      S_REQ: begin
        imem_req  = 1'b1;
        grantFire = imem_gnt;
      end
      S_WAIT: begin
        memLoad    = imem_rvalid & ~stall;
        bufCapture = imem_rvalid & stall;
      end
      S_FULL: begin
        bufLoad = ~stall;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign imem_addr = pc_q;

  // Datapath next values.  When not stalled, each cycle either loads a real
  // instruction or inserts a bubble; the link addresses are only updated by
  // real loads so decode always sees those of the last real instruction.
  always_comb begin
    outLoad   = memLoad | bufLoad;
    loadWord  = bufLoad ? buf_q : imem_rdata;
    fetchPc_d = grantFire ? pc_q : fetchPc_q;
    buf_d     = bufCapture ? imem_rdata : buf_q;
    instr_d   = instr_q;
    ds_d      = ds_q;
    ds2_d     = ds2_q;
    valid_d   = valid_q;
    if (!stall) begin
      if (outLoad) begin
        instr_d = loadWord;
        ds_d    = byteAddr(fetchPc_q, 30'd1);
        ds2_d   = byteAddr(fetchPc_q, 30'd2);
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  // Datapath registers: PC, outstanding fetch address, response buffer and
  // the outputs presented to decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      fetchPc_q <= RESET_PC;
      buf_q     <= NOP_INSTR;
      instr_q   <= NOP_INSTR;
      ds_q      <= '0;
      ds2_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      fetchPc_q <= fetchPc_d;
      buf_q     <= buf_d;
      instr_q   <= instr_d;
      ds_q      <= ds_d;
      ds2_q     <= ds2_d;
      valid_q   <= valid_d;
    end
  end

  assign instruction = instr_q;
  assign delayslot   = ds_q;
  assign delayslot2  = ds2_q;
  assign if_valid    = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perfFetched_q;
  logic [31:0] perfBubbles_q;

  // Event counters: one count per real load and one per inserted bubble.
  // Stalled cycles count as neither.  Both wrap naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perfFetched_q <= '0;
      perfBubbles_q <= '0;
    end else if (!stall) begin
      if (outLoad) begin
        perfFetched_q <= perfFetched_q + 32'd1;
      end else begin
        perfBubbles_q <= perfBubbles_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perfFetched_q;
  assign perf_bubbles = perfBubbles_q;
`else
  // Without the performance build the load/bubble events are not counted.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed, table-driven bench for fetch_stage.  Each table row is one clock
// cycle: inputs applied just after a rising edge, the fetch request checked
// before the next edge, the decode outputs checked just after it.  A second
// instance with RESET_PC at the top of the address space covers wrap-around.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0015;

  typedef struct {
    logic        stall;
    logic        br;
    logic        jp;
    logic        jar;
    logic [29:0] bt;
    logic [29:0] jt;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        eReq;
    logic [29:0] eAddr;
    logic [31:0] eInstr;
    logic [31:0] eDs;
    logic [31:0] eDs2;
    logic        eValid;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [29:0] branch_target;
  logic        jump;
  logic        jar;
  logic [29:0] jr_target;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req;
  logic [29:0] imem_addr;
  logic [31:0] instruction;
  logic [31:0] delayslot;
  logic [31:0] delayslot2;
  logic        if_valid;

  logic        wReq;
  logic [29:0] wAddr;
  logic [31:0] wInstr;
  logic [31:0] wDs;
  logic [31:0] wDs2;
  logic        wValid;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
  logic [31:0] wPerfFetched;
  logic [31:0] wPerfBubbles;
`endif

  int compared;
  int mismatched;
  vec_t vecs[$];

  fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jar           (jar),
    .jr_target     (jr_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .delayslot     (delayslot),
    .delayslot2    (delayslot2),
    .if_valid      (if_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_bubbles  (perf_bubbles)
`endif
  );

  fetch_stage #(.RESET_PC(30'h3FFF_FFFF)) dutWrap (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jar           (jar),
    .jr_target     (jr_target),
    .imem_req      (wReq),
    .imem_addr     (wAddr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instruction   (wInstr),
    .delayslot     (wDs),
    .delayslot2    (wDs2),
    .if_valid      (wValid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (wPerfFetched),
    .perf_bubbles  (wPerfBubbles)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic st, input logic br, input logic jp, input logic jr,
                              input logic [29:0] bt, input logic [29:0] jt,
                              input logic g, input logic rv, input logic [31:0] rd,
                              input logic eReq, input logic [29:0] eAddr,
                              input logic [31:0] eI, input logic [31:0] eD,
                              input logic [31:0] eD2, input logic eV);
    vec_t v;
    v.stall = st; v.br = br; v.jp = jp; v.jar = jr; v.bt = bt; v.jt = jt;
    v.gnt = g; v.rv = rv; v.rd = rd;
    v.eReq = eReq; v.eAddr = eAddr; v.eInstr = eI; v.eDs = eD; v.eDs2 = eD2; v.eValid = eV;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    stall         = v.stall;
    branch        = v.br;
    jump          = v.jp;
    jar           = v.jar;
    branch_target = v.bt;
    jr_target     = v.jt;
    imem_gnt      = v.gnt;
    imem_rvalid   = v.rv;
    imem_rdata    = v.rd;
  endtask

  task automatic checkRequest(input vec_t v, input string tag);
    check({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, v.eReq});
    check({tag, " imem_addr"}, {2'b00, imem_addr}, {2'b00, v.eAddr});
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    @(posedge clock);
    #1;
    check({tag, " instruction"}, instruction, v.eInstr);
    check({tag, " delayslot"}, delayslot, v.eDs);
    check({tag, " delayslot2"}, delayslot2, v.eDs2);
    check({tag, " if_valid"}, {31'd0, if_valid}, {31'd0, v.eValid});
  endtask

  initial begin
    int   expFetched;
    int   expBubbles;
    vec_t v;

    compared   = 0;
    mismatched = 0;
    expFetched = 0;
    expBubbles = 0;

    // Columns: stall br jp jar bt jt | gnt rv rdata | req addr | instr ds ds2 valid
    // Boot and three back-to-back fetches (memory returns data = word address).
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,          0,30'd0, NOP,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,          1,30'd0, NOP,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'd0,      0,30'd1, 32'd0,32'd4,32'd8,1));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,          1,30'd1, NOP,32'd4,32'd8,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'd1,      0,30'd2, 32'd1,32'd8,32'd12,1));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,          1,30'd2, NOP,32'd8,32'd12,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'd2,      0,30'd3, 32'd2,32'd12,32'd16,1));
    // Five stalled cycles; word 3 arrives mid-stall and is buffered.
    vecs.push_back(mk(1,0,0,0,0,0, 1,0,0,          1,30'd3, 32'd2,32'd12,32'd16,1));
    vecs.push_back(mk(1,0,0,0,0,0, 0,1,32'd3,      0,30'd4, 32'd2,32'd12,32'd16,1));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,          0,30'd4, 32'd2,32'd12,32'd16,1));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,          0,30'd4, 32'd2,32'd12,32'd16,1));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,          0,30'd4, 32'd2,32'd12,32'd16,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,          0,30'd4, 32'd3,32'd16,32'd20,1));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,          1,30'd4, NOP,32'd16,32'd20,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'd4,      0,30'd5, 32'd4,32'd20,32'd24,1));
    // Straight-line words 5..10.
    for (int w = 5; w <= 10; w++) begin
      vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,        1,30'(w), NOP,32'(w*4),32'(w*4+4),0));
      vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'(w),   0,30'(w+1), 32'(w),32'((w+1)*4),32'((w+2)*4),1));
    end
    // Word 10 is a branch to 0x40; delay-slot grant held off three cycles.
    vecs.push_back(mk(0,1,0,0,30'h40,0, 0,0,0,     1,30'd11, NOP,32'd44,32'd48,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,          1,30'd11, NOP,32'd44,32'd48,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,          1,30'd11, NOP,32'd44,32'd48,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,          1,30'd11, NOP,32'd44,32'd48,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'd11,     0,30'h40, 32'd11,32'd48,32'd52,1));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,          1,30'h40, NOP,32'd48,32'd52,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'h40,     0,30'h41, 32'h40,32'h104,32'h108,1));
    // Register jump to 0x100 arriving with the delay-slot grant.
    vecs.push_back(mk(0,0,1,1,30'h77,30'h100, 1,0,0, 1,30'h41, NOP,32'h104,32'h108,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'h41,     0,30'h100, 32'h41,32'h108,32'h10C,1));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,          1,30'h100, NOP,32'h108,32'h10C,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'h100,    0,30'h101, 32'h100,32'h404,32'h408,1));
    // Branch under stall is ignored; then branch+jump(jar) taken while waiting.
    vecs.push_back(mk(1,1,0,0,30'h200,0, 1,0,0,    1,30'h101, 32'h100,32'h404,32'h408,1));
    vecs.push_back(mk(0,1,1,1,30'h200,30'h300, 0,1,32'h101, 0,30'h102, 32'h101,32'h408,32'h40C,1));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,          1,30'h300, NOP,32'h408,32'h40C,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'h300,    0,30'h301, 32'h300,32'hC04,32'hC08,1));
    // Two pending redirects (latest wins, jar=0 uses branch_target); stray rvalid ignored.
    vecs.push_back(mk(0,1,0,0,30'h500,0, 0,1,32'hDEAD, 1,30'h301, NOP,32'hC04,32'hC08,0));
    vecs.push_back(mk(0,0,1,0,30'h600,30'h123, 0,0,0, 1,30'h301, NOP,32'hC04,32'hC08,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,          1,30'h301, NOP,32'hC04,32'hC08,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'h301,    0,30'h600, 32'h301,32'hC08,32'hC0C,1));
    // Two-cycle memory latency.
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,          1,30'h600, NOP,32'hC08,32'hC0C,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,          0,30'h601, NOP,32'hC08,32'hC0C,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'h600,    0,30'h601, 32'h600,32'h1804,32'h1808,1));

    // Reset state.
    applyStimulus(mk(0,0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0));
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset instruction", instruction, NOP);
    check("reset delayslot", delayslot, 32'd0);
    check("reset delayslot2", delayslot2, 32'd0);
    check("reset if_valid", {31'd0, if_valid}, 32'd0);
    check("reset imem_req", {31'd0, imem_req}, 32'd0);
    check("reset wrap imem_addr", {2'b00, wAddr}, 32'h3FFF_FFFF);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkRequest(vecs[i], $sformatf("row%0d", i));
      checkOutput(vecs[i], $sformatf("row%0d", i));
      if (!vecs[i].stall) begin
        if (vecs[i].eValid) expFetched++;
        else expBubbles++;
      end
    end

`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'(expFetched));
    check("perf_bubbles", perf_bubbles, 32'(expBubbles));
`endif

    // Issue a fetch, then reset asynchronously while it is outstanding.
    v = mk(0,0,0,0,0,0, 1,0,0, 1,30'h601, NOP,32'h1804,32'h1808,0);
    applyStimulus(v);
    checkRequest(v, "preReset");
    checkOutput(v, "preReset");
    applyStimulus(mk(0,0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0));
    #3;
    reset = 1'b1;
    #1;
    check("asyncReset delayslot", delayslot, 32'd0);
    check("asyncReset delayslot2", delayslot2, 32'd0);
    check("asyncReset instruction", instruction, NOP);
    check("asyncReset imem_req", {31'd0, imem_req}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Late rvalid in S_BOOT and S_REQ must be ignored; wrap instance boots at top word.
    v = mk(0,0,0,0,0,0, 0,1,32'hBAD, 0,30'd0, NOP,0,0,0);
    applyStimulus(v);
    checkRequest(v, "lateBoot");
    check("wrap boot addr", {2'b00, wAddr}, 32'h3FFF_FFFF);
    checkOutput(v, "lateBoot");
    check("wrap boot valid", {31'd0, wValid}, 32'd0);

    v = mk(0,0,0,0,0,0, 0,1,32'hBAD, 1,30'd0, NOP,0,0,0);
    applyStimulus(v);
    checkRequest(v, "lateReq");
    check("wrap first addr", {2'b00, wAddr}, 32'h3FFF_FFFF);
    checkOutput(v, "lateReq");
    check("wrap late instruction", wInstr, NOP);

    v = mk(0,0,0,0,0,0, 1,0,0, 1,30'd0, NOP,0,0,0);
    applyStimulus(v);
    checkRequest(v, "postGnt");
    checkOutput(v, "postGnt");

    v = mk(0,0,0,0,0,0, 0,1,32'h1234, 0,30'd1, 32'h1234,32'd4,32'd8,1);
    applyStimulus(v);
    checkRequest(v, "postData");
    check("wrap pc wrapped", {2'b00, wAddr}, 32'd0);
    checkOutput(v, "postData");
    check("wrap delayslot", wDs, 32'd0);
    check("wrap delayslot2", wDs2, 32'd4);
    check("wrap instruction", wInstr, 32'h1234);

    v = mk(0,0,0,0,0,0, 1,0,0, 1,30'd1, NOP,32'd4,32'd8,0);
    applyStimulus(v);
    checkRequest(v, "secondReq");
    check("wrap second req", {31'd0, wReq}, 32'd1);
    check("wrap second addr", {2'b00, wAddr}, 32'd0);
    checkOutput(v, "secondReq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
